// File: rtl/leaf_stream_bridge_pkg.sv
// leaf_stream_bridge shared definitions: default widths and level sizing.
// Imported by the interface, the per-channel FIFO and the bridge top.
package leaf_bridge_pkg;

    localparam int PAYLOAD_BITS_DEF    = 32;
    localparam int FIFO_DEPTH_BITS_DEF = 4;
    localparam int STAT_BITS           = 32;

    // An occupancy counter must hold 0..2^d inclusive, hence one extra bit.
    function automatic int level_bits(input int d);
        return d + 1;
    endfunction

endpackage

// File: rtl/leaf_stream_bridge_if.sv
// Bundle of leaf-side and kernel-side stream signals for leaf_stream_bridge.
// The beat_count member exists only when LEAF_BRIDGE_STATS_EN is defined.
interface leaf_stream_bridge_if
    import leaf_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS    = PAYLOAD_BITS_DEF,
    parameter int NUM_IN_PORTS    = 1,
    parameter int NUM_OUT_PORTS   = 1,
    parameter int FIFO_DEPTH_BITS = FIFO_DEPTH_BITS_DEF
);

    localparam int LB = level_bits(FIFO_DEPTH_BITS);

    // leaf_interface -> bridge -> kernel
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
    logic [NUM_IN_PORTS-1:0]               vld_interface2user;
    logic [NUM_IN_PORTS-1:0]               ack_user2interface;
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  m_tdata;
    logic [NUM_IN_PORTS-1:0]               m_tvalid;
    logic [NUM_IN_PORTS-1:0]               m_tready;

    // kernel -> bridge -> leaf_interface
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] s_tdata;
    logic [NUM_OUT_PORTS-1:0]              s_tvalid;
    logic [NUM_OUT_PORTS-1:0]              s_tready;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

    logic [NUM_IN_PORTS*LB-1:0]            in_level;
    logic [NUM_OUT_PORTS*LB-1:0]           out_level;

`ifdef LEAF_BRIDGE_STATS_EN
    logic [(NUM_IN_PORTS+NUM_OUT_PORTS)*STAT_BITS-1:0] beat_count;
`endif

    // Environment side: leaf_interface plus kernel.
    modport master (
        output dout_leaf_interface2user,
        output vld_interface2user,
        input  ack_user2interface,
        input  m_tdata,
        input  m_tvalid,
        output m_tready,
        output s_tdata,
        output s_tvalid,
        input  s_tready,
        input  din_leaf_user2interface,
        input  vld_user2interface,
        output ack_interface2user,
        input  in_level,
`ifdef LEAF_BRIDGE_STATS_EN
        input  beat_count,
`endif
        input  out_level
    );

    // Bridge side.
    modport slave (
        input  dout_leaf_interface2user,
        input  vld_interface2user,
        output ack_user2interface,
        output m_tdata,
        output m_tvalid,
        input  m_tready,
        input  s_tdata,
        input  s_tvalid,
        output s_tready,
        output din_leaf_user2interface,
        output vld_user2interface,
        input  ack_interface2user,
        output in_level,
`ifdef LEAF_BRIDGE_STATS_EN
        output beat_count,
`endif
        output out_level
    );

endinterface

// File: rtl/leaf_stream_bridge_fifo.sv
// leaf_stream_fifo: one synchronous FIFO, valid/ready on both sides.
// Registered output only (no bypass); level output counts 0..2^DEPTH_BITS.
module leaf_stream_fifo
    import leaf_bridge_pkg::*;
#(
    parameter int DATA_BITS  = PAYLOAD_BITS_DEF,
    parameter int DEPTH_BITS = FIFO_DEPTH_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_BITS-1:0]  i_wr_data,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    output logic [DATA_BITS-1:0]  o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [level_bits(DEPTH_BITS)-1:0] o_level
);

    localparam int LB    = level_bits(DEPTH_BITS);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [DATA_BITS-1:0]  r_mem [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [LB-1:0]         r_level;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    assign w_full  = (r_level == LB'(DEPTH));
    assign w_empty = (r_level == '0);

    // Ready comes only from registered state plus the clear inputs.
    assign o_wr_ready = !w_full && !reset && !flush;
    assign o_rd_valid = !w_empty && !reset;
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_level    = r_level;

    assign w_wr = i_wr_valid && o_wr_ready;
    assign w_rd = o_rd_valid && i_rd_ready;

    // Pointer and occupancy tracking; reset outranks flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is written on accepted beats only and never cleared.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge: per-channel FIFOs between leaf_interface and kernel.
// Define LEAF_BRIDGE_STATS_EN to add per-channel accepted-write counters.
module leaf_stream_bridge
    import leaf_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS    = PAYLOAD_BITS_DEF,
    parameter int NUM_IN_PORTS    = 1,
    parameter int NUM_OUT_PORTS   = 1,
    parameter int FIFO_DEPTH_BITS = FIFO_DEPTH_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    leaf_stream_bridge_if.slave bus
);

    localparam int PB = PAYLOAD_BITS;
    localparam int LB = level_bits(FIFO_DEPTH_BITS);

    // Inbound channels: leaf writes, kernel reads.
    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
        logic [PB-1:0] w_rd_data;
        logic          w_rd_valid;
        logic          w_wr_ready;
        logic [LB-1:0] w_level;

        leaf_stream_fifo #(
            .DATA_BITS  (PB),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .i_wr_data  (bus.dout_leaf_interface2user[i*PB +: PB]),
            .i_wr_valid (bus.vld_interface2user[i]),
            .o_wr_ready (w_wr_ready),
            .o_rd_data  (w_rd_data),
            .o_rd_valid (w_rd_valid),
            .i_rd_ready (bus.m_tready[i]),
            .o_level    (w_level)
        );

        assign bus.ack_user2interface[i]  = w_wr_ready;
        assign bus.m_tdata[i*PB +: PB]    = w_rd_data;
        assign bus.m_tvalid[i]            = w_rd_valid;
        assign bus.in_level[i*LB +: LB]   = w_level;
    end

    // Outbound channels: kernel writes, leaf reads.
    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
        logic [PB-1:0] w_rd_data;
        logic          w_rd_valid;
        logic          w_wr_ready;
        logic [LB-1:0] w_level;

        leaf_stream_fifo #(
            .DATA_BITS  (PB),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .i_wr_data  (bus.s_tdata[j*PB +: PB]),
            .i_wr_valid (bus.s_tvalid[j]),
            .o_wr_ready (w_wr_ready),
            .o_rd_data  (w_rd_data),
            .o_rd_valid (w_rd_valid),
            .i_rd_ready (bus.ack_interface2user[j]),
            .o_level    (w_level)
        );

        assign bus.s_tready[j]                          = w_wr_ready;
        assign bus.din_leaf_user2interface[j*PB +: PB]  = w_rd_data;
        assign bus.vld_user2interface[j]                = w_rd_valid;
        assign bus.out_level[j*LB +: LB]                = w_level;
    end

`ifdef LEAF_BRIDGE_STATS_EN
    // Inbound beat counters occupy the low slots of beat_count.
    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in_stat
        logic [STAT_BITS-1:0] r_beats;

        // Count accepted leaf writes; survives flush, wraps naturally.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_beats <= '0;
            end else if (bus.vld_interface2user[i] && bus.ack_user2interface[i]) begin
                r_beats <= r_beats + 1'b1;
            end
        end

        assign bus.beat_count[i*STAT_BITS +: STAT_BITS] = r_beats;
    end

    // Outbound beat counters follow the inbound ones.
    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out_stat
        localparam int C = NUM_IN_PORTS + j;
        logic [STAT_BITS-1:0] r_beats;

        // Count accepted kernel writes; survives flush, wraps naturally.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_beats <= '0;
            end else if (bus.s_tvalid[j] && bus.s_tready[j]) begin
                r_beats <= r_beats + 1'b1;
            end
        end

        assign bus.beat_count[C*STAT_BITS +: STAT_BITS] = r_beats;
    end
`endif

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Directed bench for leaf_stream_bridge: one inbound, two outbound channels.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_leaf_stream_bridge;

    localparam int PB = 32;
    localparam int NI = 1;
    localparam int NO = 2;
    localparam int DB = 4;
    localparam int LB = DB + 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    int errors = 0;
    int checks = 0;

    leaf_stream_bridge_if #(
        .PAYLOAD_BITS    (PB),
        .NUM_IN_PORTS    (NI),
        .NUM_OUT_PORTS   (NO),
        .FIFO_DEPTH_BITS (DB)
    ) bus ();

    leaf_stream_bridge #(
        .PAYLOAD_BITS    (PB),
        .NUM_IN_PORTS    (NI),
        .NUM_OUT_PORTS   (NO),
        .FIFO_DEPTH_BITS (DB)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.vld_interface2user = 1'b1;
        bus.dout_leaf_interface2user = 32'h11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.ack_user2interface !== 1'b0) begin
                errors++;
                $display("FAIL reset_ack: got %b want 0", bus.ack_user2interface);
            end
            checks++;
            if (bus.s_tready !== 2'b00) begin
                errors++;
                $display("FAIL reset_s_tready: got %b want 00", bus.s_tready);
            end
            tick();
        end
        reset = 1'b0;
        bus.vld_interface2user = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ack_user2interface !== 1'b1) begin
            errors++;
            $display("FAIL release_ack: got %b want 1", bus.ack_user2interface);
        end
        checks++;
        if (bus.m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL release_m_tvalid: got %b want 0", bus.m_tvalid);
        end
        checks++;
        if (bus.in_level !== 5'd0) begin
            errors++;
            $display("FAIL release_in_level: got %0d want 0", bus.in_level);
        end
        checks++;
        if (bus.vld_user2interface !== 2'b00 || bus.out_level !== 10'd0) begin
            errors++;
            $display("FAIL release_out: got vld %b lvl %h want 00/0",
                     bus.vld_user2interface, bus.out_level);
        end
        checks++;
        if (bus.s_tready !== 2'b11) begin
            errors++;
            $display("FAIL release_s_tready: got %b want 11", bus.s_tready);
        end
        tick();
    endtask

    task automatic test_latency();
        bus.m_tready = 1'b0;
        bus.dout_leaf_interface2user = 32'hDEADBEEF;
        bus.vld_interface2user = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass: got m_tvalid %b want 0", bus.m_tvalid);
        end
        tick();
        bus.vld_interface2user = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL latency: got v=%b d=%h want 1/deadbeef",
                     bus.m_tvalid, bus.m_tdata);
        end
        checks++;
        if (bus.in_level !== 5'd1) begin
            errors++;
            $display("FAIL latency_level: got %0d want 1", bus.in_level);
        end
        tick();
        bus.m_tready = 1'b1;
        tick();
        bus.m_tready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_level !== 5'd0 || bus.m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_drain: got lvl %0d v %b want 0/0",
                     bus.in_level, bus.m_tvalid);
        end
        tick();
    endtask

    task automatic test_fill();
        bus.m_tready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.dout_leaf_interface2user = k;
            bus.vld_interface2user = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.ack_user2interface !== 1'b1) begin
                errors++;
                $display("FAIL fill_ack_%0d: got %b want 1", k, bus.ack_user2interface);
            end
            tick();
        end
        bus.dout_leaf_interface2user = 32'h99;
        @(negedge clk);
        checks++;
        if (bus.ack_user2interface !== 1'b0 || bus.in_level !== 5'd16) begin
            errors++;
            $display("FAIL full: got ack %b lvl %0d want 0/16",
                     bus.ack_user2interface, bus.in_level);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.in_level !== 5'd16) begin
            errors++;
            $display("FAIL full_hold: got lvl %0d want 16", bus.in_level);
        end
        tick();
        bus.vld_interface2user = 1'b0;
        bus.m_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'(k)) begin
                errors++;
                $display("FAIL drain_%0d: got v=%b d=%h want 1/%h",
                         k, bus.m_tvalid, bus.m_tdata, k);
            end
            if (k < 2) begin
                checks++;
                if (bus.ack_user2interface !== (k == 1)) begin
                    errors++;
                    $display("FAIL drain_ack_%0d: got %b want %b",
                             k, bus.ack_user2interface, (k == 1));
                end
            end
            tick();
        end
        bus.m_tready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_level !== 5'd0 || bus.m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL drained: got lvl %0d v %b want 0/0",
                     bus.in_level, bus.m_tvalid);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        bus.m_tready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.dout_leaf_interface2user = 100 + k;
            bus.vld_interface2user = 1'b1;
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            bus.dout_leaf_interface2user = 108 + k;
            bus.vld_interface2user = 1'b1;
            bus.m_tready = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.in_level !== 5'd8 || bus.m_tdata !== 32'(100 + k)) begin
                errors++;
                $display("FAIL simul_%0d: got lvl %0d d %0d want 8/%0d",
                         k, bus.in_level, bus.m_tdata, 100 + k);
            end
            tick();
        end
        bus.vld_interface2user = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'(120 + k)) begin
                errors++;
                $display("FAIL simul_tail_%0d: got v=%b d=%0d want 1/%0d",
                         k, bus.m_tvalid, bus.m_tdata, 120 + k);
            end
            tick();
        end
        bus.m_tready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_level !== 5'd0) begin
            errors++;
            $display("FAIL simul_empty: got lvl %0d want 0", bus.in_level);
        end
        tick();
    endtask

    task automatic test_multi_channel();
        int cnt0 = 0;
        int cnt1 = 0;
        int rcv0 = 0;
        int cyc  = 0;
        bus.ack_interface2user = 2'b01;
        while (rcv0 < 100 && cyc < 300) begin
            bus.s_tvalid = {1'b1, (cnt0 < 100)};
            bus.s_tdata  = {32'(2000 + cnt1), 32'(1000 + cnt0)};
            @(negedge clk);
            if (bus.vld_user2interface[0]) begin
                checks++;
                if (bus.din_leaf_user2interface[31:0] !== 32'(1000 + rcv0)) begin
                    errors++;
                    $display("FAIL ch0_word_%0d: got %0d want %0d", rcv0,
                             bus.din_leaf_user2interface[31:0], 1000 + rcv0);
                end
                rcv0++;
            end
            if (bus.s_tvalid[0] && bus.s_tready[0]) cnt0++;
            if (bus.s_tready[1]) cnt1++;
            cyc++;
            tick();
        end
        bus.s_tvalid = 2'b00;
        checks++;
        if (rcv0 != 100) begin
            errors++;
            $display("FAIL ch0_count: got %0d want 100", rcv0);
        end
        @(negedge clk);
        checks++;
        if (bus.out_level[9:5] !== 5'd16 || bus.s_tready[1] !== 1'b0) begin
            errors++;
            $display("FAIL ch1_full: got lvl %0d rdy %b want 16/0",
                     bus.out_level[9:5], bus.s_tready[1]);
        end
        checks++;
        if (cnt1 != 16) begin
            errors++;
            $display("FAIL ch1_accepts: got %0d want 16", cnt1);
        end
        tick();
        bus.ack_interface2user = 2'b10;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (bus.vld_user2interface[1] !== 1'b1 ||
                bus.din_leaf_user2interface[63:32] !== 32'(2000 + k)) begin
                errors++;
                $display("FAIL ch1_word_%0d: got v=%b d=%0d want 1/%0d", k,
                         bus.vld_user2interface[1],
                         bus.din_leaf_user2interface[63:32], 2000 + k);
            end
            tick();
        end
        bus.ack_interface2user = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.out_level !== 10'd0) begin
            errors++;
            $display("FAIL out_empty: got %h want 0", bus.out_level);
        end
        tick();
    endtask

    task automatic test_flush();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.dout_leaf_interface2user = 32'h500 + k;
            bus.vld_interface2user = 1'b1;
            tick();
        end
        bus.vld_interface2user = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_level !== 5'd5 || bus.m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL pre_flush: got lvl %0d v %b want 5/1",
                     bus.in_level, bus.m_tvalid);
        end
        tick();
        flush = 1'b1;
        bus.vld_interface2user = 1'b1;
        bus.dout_leaf_interface2user = 32'hBAD;
        @(negedge clk);
        checks++;
        if (bus.ack_user2interface !== 1'b0 || bus.s_tready !== 2'b00) begin
            errors++;
            $display("FAIL flush_ready: got ack %b s_rdy %b want 0/00",
                     bus.ack_user2interface, bus.s_tready);
        end
        tick();
        flush = 1'b0;
        bus.vld_interface2user = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_level !== 5'd0 || bus.m_tvalid !== 1'b0 ||
            bus.ack_user2interface !== 1'b1) begin
            errors++;
            $display("FAIL post_flush: got lvl %0d v %b ack %b want 0/0/1",
                     bus.in_level, bus.m_tvalid, bus.ack_user2interface);
        end
`ifdef LEAF_BRIDGE_STATS_EN
        checks++;
        if (bus.beat_count[31:0] !== 32'd5) begin
            errors++;
            $display("FAIL beat_count: got %0d want 5", bus.beat_count[31:0]);
        end
`endif
        tick();
        bus.dout_leaf_interface2user = 32'h77;
        bus.vld_interface2user = 1'b1;
        tick();
        bus.vld_interface2user = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'h77) begin
            errors++;
            $display("FAIL after_flush: got v=%b d=%h want 1/77",
                     bus.m_tvalid, bus.m_tdata);
        end
        tick();
        bus.m_tready = 1'b1;
        tick();
        bus.m_tready = 1'b0;
    endtask

    initial begin
        bus.dout_leaf_interface2user = '0;
        bus.vld_interface2user = '0;
        bus.m_tready = '0;
        bus.s_tdata = '0;
        bus.s_tvalid = '0;
        bus.ack_interface2user = '0;
        test_reset();
        test_latency();
        test_fill();
        test_simultaneous();
        test_multi_channel();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
